// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared ALUctr codes, op/func constants, mux encodings and state enum for mc_ctrl_fsm
package mc_ctrl_pkg;
  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SUBU = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [1:0] SRCB_BUSB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_IFETCH, S_DECODE, S_BR, S_JMP, S_R_EXEC, S_R_WB,
    S_I_EXEC, S_I_WB, S_MEM_ADR, S_LW_MEM, S_LW_WB, S_SW_MEM
  } state_t;
endpackage

// File: rtl/mc_ctrl_fsm_alu_func_decode.sv
// alu_func_decode: R-type func -> ALUctr, legality and overflow-capable flag (combinational)
//   i_func     R-type function field IR[5:0]
//   o_alu_ctr  ALUctr code for the dispatcher
//   o_legal    func is one of add/addu/sub/subu/slt/sltu
//   o_ov_cap   func is a trapping add/sub
module alu_func_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_func,
  output logic [2:0] o_alu_ctr,
  output logic       o_legal,
  output logic       o_ov_cap
);
  always_comb begin
    o_alu_ctr = ALU_ADDU;
    o_legal = 1'b1;
    case (i_func)
      FN_ADD:  o_alu_ctr = ALU_ADD;
      FN_ADDU: o_alu_ctr = ALU_ADDU;
      FN_SUB:  o_alu_ctr = ALU_SUB;
      FN_SUBU: o_alu_ctr = ALU_SUBU;
      FN_SLT:  o_alu_ctr = ALU_SLT;
      FN_SLTU: o_alu_ctr = ALU_SLTU;
      default: o_legal = 1'b0;
    endcase
    o_ov_cap = (i_func == FN_ADD) || (i_func == FN_SUB);
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS-subset control FSM driving datapath enables and ALUctr
//   in : clk, rst (sync, active-high), op[5:0], func[5:0], Overflow, MemReady
//   out: PCWr PCWrCond IorD MemWr IRWr RegDst RegWr MemtoReg ExtOp ALUSrcA ALUSrcB[1:0]
//        ALUctr[2:0] PCSource[1:0] IllInstr OvTrap
//   USE_MEM_READY=0 treats MemReady as always 1.
//   MC_CTRL_OVF_TRAP_EN: suppress R-type writeback on add/sub overflow and pulse OvTrap.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       Overflow,
  input  logic       MemReady,
  output logic       PCWr,
  output logic       PCWrCond,
  output logic       IorD,
  output logic       MemWr,
  output logic       IRWr,
  output logic       RegDst,
  output logic       RegWr,
  output logic       MemtoReg,
  output logic       ExtOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUctr,
  output logic [1:0] PCSource,
  output logic       IllInstr,
  output logic       OvTrap
);
  state_t r_state, w_next, w_dec;
  logic [2:0] w_fn_ctr;
  logic w_legal, w_ov_cap, w_rdy;
  alu_func_decode u_dec (.i_func(func), .o_alu_ctr(w_fn_ctr), .o_legal(w_legal), .o_ov_cap(w_ov_cap));
  assign w_rdy = USE_MEM_READY ? MemReady : 1'b1;
  // IFETCH on w_dec flags an unsupported instruction
  assign w_dec = (op == OP_BEQ) ? S_BR :
                 (op == OP_J) ? S_JMP :
                 (op == OP_R) ? (w_legal ? S_R_EXEC : S_IFETCH) :
                 (op == OP_ORI || op == OP_ADDIU) ? S_I_EXEC :
                 (op == OP_LW || op == OP_SW) ? S_MEM_ADR : S_IFETCH;
  always_ff @(posedge clk) r_state <= rst ? S_IFETCH : w_next;
`ifdef MC_CTRL_OVF_TRAP_EN
  logic r_ov;
  always_ff @(posedge clk)
    r_ov <= (rst || r_state == S_IFETCH) ? 1'b0 :
            (r_state == S_R_EXEC) ? (Overflow & w_ov_cap) : r_ov;
`else
  logic w_unused;
  assign w_unused = Overflow ^ w_ov_cap;
`endif
  // outputs are gated by rst so a reset abandons an in-flight write the same cycle
  always_comb begin
    w_next = rst ? S_IFETCH : r_state;
    PCWr = 1'b0;
    PCWrCond = 1'b0;
    IorD = 1'b0;
    MemWr = 1'b0;
    IRWr = 1'b0;
    RegDst = 1'b0;
    RegWr = 1'b0;
    MemtoReg = 1'b0;
    ExtOp = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = SRCB_BUSB;
    ALUctr = ALU_ADDU;
    PCSource = PCS_ALU;
    IllInstr = 1'b0;
    OvTrap = 1'b0;
    if (!rst)
      case (r_state)
        S_IFETCH: begin
          ALUSrcB = SRCB_FOUR;
          IRWr = w_rdy;
          PCWr = w_rdy;
          w_next = w_rdy ? S_DECODE : S_IFETCH;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_BR;
          ExtOp = 1'b1;
          IllInstr = (w_dec == S_IFETCH);
          w_next = w_dec;
        end
        S_BR: begin
          ALUSrcA = 1'b1;
          ALUctr = ALU_SUBU;
          PCWrCond = 1'b1;
          PCSource = PCS_ALUOUT;
          w_next = S_IFETCH;
        end
        S_JMP: begin
          PCWr = 1'b1;
          PCSource = PCS_JUMP;
          w_next = S_IFETCH;
        end
        S_R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUctr = w_fn_ctr;
          w_next = S_R_WB;
        end
        S_R_WB: begin
          RegDst = 1'b1;
`ifdef MC_CTRL_OVF_TRAP_EN
          RegWr = ~r_ov;
          OvTrap = r_ov;
`else
          RegWr = 1'b1;
`endif
          w_next = S_IFETCH;
        end
        S_I_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ExtOp = (op == OP_ADDIU);
          ALUctr = (op == OP_ORI) ? ALU_OR : ALU_ADDU;
          w_next = S_I_WB;
        end
        S_I_WB: begin
          RegWr = 1'b1;
          w_next = S_IFETCH;
        end
        S_MEM_ADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ExtOp = 1'b1;
          w_next = (op == OP_LW) ? S_LW_MEM : S_SW_MEM;
        end
        S_LW_MEM: begin
          IorD = 1'b1;
          w_next = w_rdy ? S_LW_WB : S_LW_MEM;
        end
        S_LW_WB: begin
          RegWr = 1'b1;
          MemtoReg = 1'b1;
          w_next = S_IFETCH;
        end
        S_SW_MEM: begin
          IorD = 1'b1;
          MemWr = 1'b1;
          w_next = w_rdy ? S_IFETCH : S_SW_MEM;
        end
        default: w_next = S_IFETCH;
      endcase
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized per-instruction cycle-trace model checked against mc_ctrl_fsm
module tb_mc_ctrl_fsm;
  typedef struct packed {
    logic pcwr, pcwrcond, iord, memwr, irwr, regdst, regwr, memtoreg, extop, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluctr;
    logic [1:0] pcsource;
    logic ill, ovt;
  } ctl_t;
  typedef struct {
    ctl_t e;
    logic mr;
    logic ov;
  } cyc_t;
  logic clk = 1'b0, rst = 1'b1, Overflow = 1'b0, MemReady = 1'b1;
  logic [5:0] op = '0, func = '0;
  logic PCWr, PCWrCond, IorD, MemWr, IRWr, RegDst, RegWr, MemtoReg, ExtOp, ALUSrcA, IllInstr, OvTrap;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUctr;
  ctl_t act;
  cyc_t q[$];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .Overflow(Overflow), .MemReady(MemReady),
    .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .MemWr(MemWr), .IRWr(IRWr), .RegDst(RegDst),
    .RegWr(RegWr), .MemtoReg(MemtoReg), .ExtOp(ExtOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUctr(ALUctr), .PCSource(PCSource), .IllInstr(IllInstr), .OvTrap(OvTrap)
  );
  assign act = {PCWr, PCWrCond, IorD, MemWr, IRWr, RegDst, RegWr, MemtoReg, ExtOp, ALUSrcA,
                ALUSrcB, ALUctr, PCSource, IllInstr, OvTrap};
  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction
  function automatic logic [2:0] rcode(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b001;
      6'b100010: return 3'b101;
      6'b100011: return 3'b100;
      6'b101010: return 3'b111;
      6'b101011: return 3'b110;
      default:   return 3'b000;
    endcase
  endfunction
  function automatic logic is_legal(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000)
      return f inside {6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b101010, 6'b101011};
    return o inside {6'b000010, 6'b000100, 6'b001001, 6'b001101, 6'b100011, 6'b101011};
  endfunction
  function automatic void add(input ctl_t e, input logic mr, input logic ov);
    cyc_t c;
    c.e = e;
    c.mr = mr;
    c.ov = ov;
    q.push_back(c);
  endfunction
  // expected per-cycle outputs for one instruction: wf/wm are memory wait cycles in fetch/data access
  function automatic void build(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm,
                                input logic ov);
    ctl_t c;
    logic trap;
    q.delete();
    for (int i = 0; i < wf; i++) begin
      c = '0; c.alusrcb = 2'b01; add(c, 1'b0, rb());
    end
    c = '0; c.alusrcb = 2'b01; c.irwr = 1'b1; c.pcwr = 1'b1; add(c, 1'b1, rb());
    c = '0; c.alusrcb = 2'b11; c.extop = 1'b1; c.ill = !is_legal(o, f); add(c, rb(), rb());
    if (!is_legal(o, f)) return;
    case (o)
      6'b000000: begin
        c = '0; c.alusrca = 1'b1; c.aluctr = rcode(f); add(c, rb(), ov);
        trap = 1'b0;
`ifdef MC_CTRL_OVF_TRAP_EN
        trap = ov && (f == 6'b100000 || f == 6'b100010);
`endif
        c = '0; c.regdst = 1'b1; c.regwr = !trap; c.ovt = trap; add(c, rb(), rb());
      end
      6'b001101, 6'b001001: begin
        c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.extop = (o == 6'b001001);
        c.aluctr = (o == 6'b001101) ? 3'b010 : 3'b000; add(c, rb(), rb());
        c = '0; c.regwr = 1'b1; add(c, rb(), rb());
      end
      6'b100011, 6'b101011: begin
        c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.extop = 1'b1; add(c, rb(), rb());
        c = '0; c.iord = 1'b1; c.memwr = (o == 6'b101011);
        for (int i = 0; i < wm; i++) add(c, 1'b0, rb());
        add(c, 1'b1, rb());
        if (o == 6'b100011) begin
          c = '0; c.regwr = 1'b1; c.memtoreg = 1'b1; add(c, rb(), rb());
        end
      end
      6'b000100: begin
        c = '0; c.alusrca = 1'b1; c.aluctr = 3'b100; c.pcwrcond = 1'b1; c.pcsource = 2'b01;
        add(c, rb(), rb());
      end
      default: begin
        c = '0; c.pcwr = 1'b1; c.pcsource = 2'b10; add(c, rb(), rb());
      end
    endcase
  endfunction
  // plays q from IFETCH; abort_at >= 0 asserts rst on that cycle and expects every output low
  task automatic run(input string name, input logic [5:0] o, input logic [5:0] f, input int abort_at);
    op = o;
    func = f;
    foreach (q[i]) begin
      MemReady = q[i].mr;
      Overflow = q[i].ov;
      rst = (i == abort_at);
      @(negedge clk);
      n_cmp++;
      if (rst ? (act !== ctl_t'(0)) : (act !== q[i].e)) begin
        n_err++;
        $display("FAIL %s cyc%0d op=%b func=%b got=%h want=%h", name, i, o, f, act,
                 rst ? ctl_t'(0) : q[i].e);
      end
      @(posedge clk);
      #1;
      if (rst) begin
        rst = 1'b0;
        return;
      end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (act !== ctl_t'(0)) begin
        n_err++;
        $display("FAIL reset cyc%0d got=%h want=0", i, act);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    build(6'b000000, 6'b100001, 0, 0, 1'b0);
    run("post_reset_addu", 6'b000000, 6'b100001, -1);
  endtask
  task automatic test_overflow();
    build(6'b000000, 6'b100000, 0, 0, 1'b1);
    run("add_ovf", 6'b000000, 6'b100000, -1);
    build(6'b000000, 6'b100010, 1, 0, 1'b1);
    run("sub_ovf", 6'b000000, 6'b100010, -1);
    build(6'b000000, 6'b100001, 0, 0, 1'b1);
    run("addu_ovf_ignored", 6'b000000, 6'b100001, -1);
  endtask
  task automatic test_lw_wait();
    build(6'b100011, 6'b000000, 0, 2, 1'b0);
    run("lw_wait2", 6'b100011, 6'b000000, -1);
    build(6'b101011, 6'b000000, 2, 1, 1'b0);
    run("sw_wait", 6'b101011, 6'b000000, -1);
  endtask
  task automatic test_branch_jump();
    build(6'b000100, 6'b000000, 0, 0, 1'b0);
    run("beq", 6'b000100, 6'b000000, -1);
    build(6'b000010, 6'b000000, 0, 0, 1'b0);
    run("j", 6'b000010, 6'b000000, -1);
  endtask
  task automatic test_illegal();
    build(6'b111111, 6'b100000, 0, 0, 1'b0);
    run("ill_op", 6'b111111, 6'b100000, -1);
    build(6'b000000, 6'b000000, 0, 0, 1'b0);
    run("ill_func", 6'b000000, 6'b000000, -1);
  endtask
  task automatic test_reset_mid_sw();
    build(6'b101011, 6'b000000, 0, 3, 1'b0);
    run("sw_rst", 6'b101011, 6'b000000, 4);
    build(6'b001101, 6'b000000, 0, 0, 1'b0);
    run("ori_after_rst", 6'b001101, 6'b000000, -1);
  endtask
  task automatic test_random();
    logic [5:0] ops[10] = '{6'b000000, 6'b000000, 6'b001101, 6'b001001, 6'b100011,
                            6'b101011, 6'b000100, 6'b000010, 6'b000000, 6'b000000};
    logic [5:0] fns[7] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b101010,
                           6'b101011, 6'b000000};
    logic [5:0] o, f;
    for (int n = 0; n < 60; n++) begin
      o = ($urandom_range(9, 0) == 0) ? 6'($urandom) : ops[$urandom_range(9, 0)];
      f = ($urandom_range(7, 0) == 0) ? 6'($urandom) : fns[$urandom_range(6, 0)];
      build(o, f, $urandom_range(2, 0), $urandom_range(3, 0), rb());
      run("random", o, f, -1);
    end
  endtask
  initial begin
    test_reset();
    test_overflow();
    test_lw_wait();
    test_branch_jump();
    test_illegal();
    test_reset_mid_sw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
